// File: rtl/riscv_demux3_buf_if.sv
// ---------------------------------------------------------------------------
// riscv_demux3_buf_if
//
// Purpose:
//   Bundles the handshake and data signals of the 1-to-3 steering buffer so
//   the producer, the three consumers and the block itself share one
//   connection object.
//
// Signal summary:
//   i_riscv_demux3_valid      producer -> block   input word valid
//   o_riscv_demux3_ready      block -> producer   block accepts word this cycle
//   i_riscv_demux3_sel[1:0]   producer -> block   00/01/10 = channel, 11 = drop
//   i_riscv_demux3_in         producer -> block   input data word
//   o_riscv_demux3_validN     block -> consumerN  channel N holds a word
//   i_riscv_demux3_readyN     consumerN -> block  consumer N takes the word
//   o_riscv_demux3_outN       block -> consumerN  channel N data (registered)
//   o_riscv_demux3_drop_cnt   block -> observer   saturating discard count
//   o_riscv_demux3_busy       block -> observer   any channel holds a word
//
// Modports:
//   slave  - the steering block itself
//   master - the environment (producer plus the three consumers)
// ---------------------------------------------------------------------------
interface riscv_demux3_buf_if #(
  parameter int width     = 64,
  parameter int cnt_width = 8
);

  logic                 i_riscv_demux3_valid;
  logic                 o_riscv_demux3_ready;
  logic [1:0]           i_riscv_demux3_sel;
  logic [width-1:0]     i_riscv_demux3_in;

  logic                 o_riscv_demux3_valid0;
  logic                 o_riscv_demux3_valid1;
  logic                 o_riscv_demux3_valid2;
  logic                 i_riscv_demux3_ready0;
  logic                 i_riscv_demux3_ready1;
  logic                 i_riscv_demux3_ready2;
  logic [width-1:0]     o_riscv_demux3_out0;
  logic [width-1:0]     o_riscv_demux3_out1;
  logic [width-1:0]     o_riscv_demux3_out2;

  logic [cnt_width-1:0] o_riscv_demux3_drop_cnt;
  logic                 o_riscv_demux3_busy;

  // The block receives the input stream and consumer readies, and drives
  // everything the producer and consumers observe.
  modport slave (
    input  i_riscv_demux3_valid,
    input  i_riscv_demux3_sel,
    input  i_riscv_demux3_in,
    input  i_riscv_demux3_ready0,
    input  i_riscv_demux3_ready1,
    input  i_riscv_demux3_ready2,
    output o_riscv_demux3_ready,
    output o_riscv_demux3_valid0,
    output o_riscv_demux3_valid1,
    output o_riscv_demux3_valid2,
    output o_riscv_demux3_out0,
    output o_riscv_demux3_out1,
    output o_riscv_demux3_out2,
    output o_riscv_demux3_drop_cnt,
    output o_riscv_demux3_busy
  );

  // Mirror image for whoever drives the block.
  modport master (
    output i_riscv_demux3_valid,
    output i_riscv_demux3_sel,
    output i_riscv_demux3_in,
    output i_riscv_demux3_ready0,
    output i_riscv_demux3_ready1,
    output i_riscv_demux3_ready2,
    input  o_riscv_demux3_ready,
    input  o_riscv_demux3_valid0,
    input  o_riscv_demux3_valid1,
    input  o_riscv_demux3_valid2,
    input  o_riscv_demux3_out0,
    input  o_riscv_demux3_out1,
    input  o_riscv_demux3_out2,
    input  o_riscv_demux3_drop_cnt,
    input  o_riscv_demux3_busy
  );

endinterface

// File: rtl/riscv_demux3_buf.sv
// ---------------------------------------------------------------------------
// riscv_demux3_buf
//
// Purpose:
//   Registered 1-to-3 steering block. One valid/ready producer stream carries
//   a 2-bit destination select; each word is routed into one of three
//   single-entry channel buffers. Select 2'b11 is reserved: the word is
//   accepted, thrown away and counted in a saturating drop counter.
//
// Ports:
//   i_riscv_demux3_clk   clock, all state changes on the rising edge
//   i_riscv_demux3_rst   synchronous active-high reset, beats any transfer
//   bus                  riscv_demux3_buf_if.slave carrying the input
//                        stream, three channel outputs, drop count and busy
//
// Parameters:
//   width      data bits per word
//   cnt_width  width of the saturating drop counter
// ---------------------------------------------------------------------------
module riscv_demux3_buf #(
  parameter int width     = 64,
  parameter int cnt_width = 8
) (
  input logic               i_riscv_demux3_clk,
  input logic               i_riscv_demux3_rst,
  riscv_demux3_buf_if.slave bus
);

  localparam logic [cnt_width-1:0] CntOne = {{(cnt_width-1){1'b0}}, 1'b1};

  // Channel buffer state: one valid bit and one data word per channel.
  logic [2:0]           chanValid_q;
  logic [2:0]           chanValid_d;
  logic [width-1:0]     chanOut_q [3];
  logic [width-1:0]     chanOut_d [3];
  logic [cnt_width-1:0] dropCnt_q;
  logic [cnt_width-1:0] dropCnt_d;

  logic [2:0]           consumerReady;
  logic [2:0]           drainMask;
  logic [2:0]           routeMask;
  logic                 discardSel;
  logic                 inReady;
  logic                 accept;

  // Gather the consumer readies into a vector so every channel can be
  // handled by the same indexed logic below. A channel drains only when it
  // actually holds a word and its consumer takes it.
  assign consumerReady = {bus.i_riscv_demux3_ready2,
                          bus.i_riscv_demux3_ready1,
                          bus.i_riscv_demux3_ready0};
  assign drainMask     = chanValid_q & consumerReady;

  // Decode the select into a one-hot channel route and work out whether the
  // selected destination has room. A full channel still has room when its
  // consumer drains it this cycle, which gives pass-through with no bubble.
  // The discard code always has room. i_valid is deliberately kept out of
  // this path so the producer can look at ready before committing.
  always_comb begin
    routeMask  = 3'b000;
    discardSel = 1'b0;
    inReady    = 1'b1;
    case (bus.i_riscv_demux3_sel)
      2'b00: begin
        routeMask = 3'b001;
        inReady   = ~chanValid_q[0] | consumerReady[0];
      end
      2'b01: begin
        routeMask = 3'b010;
        inReady   = ~chanValid_q[1] | consumerReady[1];
      end
      2'b10: begin
        routeMask = 3'b100;
        inReady   = ~chanValid_q[2] | consumerReady[2];
      end
      default: begin
        discardSel = 1'b1;
        inReady    = 1'b1;
      end
    endcase
  end

  assign accept = bus.i_riscv_demux3_valid & inReady;

  // Next-state for each channel. A fresh word landing in a channel wins over
  // that channel's drain, so a drain plus an accept in the same cycle leaves
  // the channel full with the new word. Without a new word, a drain just
  // clears valid; the stale data is left in place since nobody looks at it.
  // Channels not addressed by the current word drain independently.
  // The drop counter advances only on a discard accept and sticks at
  // all-ones once it gets there.
  always_comb begin
    chanValid_d = chanValid_q;
    dropCnt_d   = dropCnt_q;
    for (int n = 0; n < 3; n++) begin
      chanOut_d[n] = chanOut_q[n];
      if (accept && routeMask[n]) begin
        chanOut_d[n]   = bus.i_riscv_demux3_in;
        chanValid_d[n] = 1'b1;
      end else if (drainMask[n]) begin
        chanValid_d[n] = 1'b0;
      end
    end
    if (accept && discardSel && (dropCnt_q != {cnt_width{1'b1}})) begin
      dropCnt_d = dropCnt_q + CntOne;
    end
  end

  // State registers. Reset clears every channel and the counter and is
  // checked first, so anything accepted or drained on a reset edge is lost.
  always_ff @(posedge i_riscv_demux3_clk) begin
    if (i_riscv_demux3_rst) begin
      chanValid_q <= 3'b000;
      dropCnt_q   <= '0;
      for (int n = 0; n < 3; n++) begin
        chanOut_q[n] <= '0;
      end
    end else begin
      chanValid_q <= chanValid_d;
      dropCnt_q   <= dropCnt_d;
      for (int n = 0; n < 3; n++) begin
        chanOut_q[n] <= chanOut_d[n];
      end
    end
  end

  // Outputs. Channel data, valids and the counter come straight from
  // registers; busy is a pure OR of registered valids, and ready is the only
  // combinational handshake output.
  assign bus.o_riscv_demux3_ready    = inReady;
  assign bus.o_riscv_demux3_valid0   = chanValid_q[0];
  assign bus.o_riscv_demux3_valid1   = chanValid_q[1];
  assign bus.o_riscv_demux3_valid2   = chanValid_q[2];
  assign bus.o_riscv_demux3_out0     = chanOut_q[0];
  assign bus.o_riscv_demux3_out1     = chanOut_q[1];
  assign bus.o_riscv_demux3_out2     = chanOut_q[2];
  assign bus.o_riscv_demux3_drop_cnt = dropCnt_q;
  assign bus.o_riscv_demux3_busy     = |chanValid_q;

endmodule

// File: tb/tb_riscv_demux3_buf.sv
// ---------------------------------------------------------------------------
// tb_riscv_demux3_buf
//
// Purpose:
//   Self-checking bench for riscv_demux3_buf. Directed stimulus pushes the
//   expected word into a per-channel queue when the word is accepted; an
//   independent monitor compares every channel against those queues on each
//   falling edge and pops a word when the consumer takes it.
// ---------------------------------------------------------------------------
module tb_riscv_demux3_buf;

  localparam int Width    = 64;
  localparam int CntWidth = 8;
  localparam int WaitMax  = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  riscv_demux3_buf_if #(.width(Width), .cnt_width(CntWidth)) bus ();

  riscv_demux3_buf #(.width(Width), .cnt_width(CntWidth)) dut (
    .i_riscv_demux3_clk (clock),
    .i_riscv_demux3_rst (reset),
    .bus                (bus)
  );

  logic [63:0]         expQ0 [$];
  logic [63:0]         expQ1 [$];
  logic [63:0]         expQ2 [$];
  logic [CntWidth-1:0] dropExp = '0;
  int                  checksDone   = 0;
  int                  checksPassed = 0;
  bit                  monitorOn    = 1'b0;

  // Compare one observed value against its expectation and keep the tally.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checksDone++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Present one word, wait (bounded) for ready, let the edge take it and
  // record what the DUT should now hold. waited reports stall cycles.
  task automatic applyStimulus(input logic [1:0] sel, input logic [63:0] data,
                               output int waited);
    waited = 0;
    bus.i_riscv_demux3_valid = 1'b1;
    bus.i_riscv_demux3_sel   = sel;
    bus.i_riscv_demux3_in    = data;
    forever begin
      @(negedge clock);
      if (bus.o_riscv_demux3_ready) break;
      waited++;
      if (waited > WaitMax) break;
    end
    if (waited > WaitMax) begin
      checkOutput("accept_timeout", 64'(waited), 64'd0);
      bus.i_riscv_demux3_valid = 1'b0;
      return;
    end
    @(posedge clock);
    case (sel)
      2'b00: expQ0.push_back(data);
      2'b01: expQ1.push_back(data);
      2'b10: expQ2.push_back(data);
      default: if (dropExp != {CntWidth{1'b1}}) dropExp++;
    endcase
    #1;
    bus.i_riscv_demux3_valid = 1'b0;
  endtask

  // Per-channel monitor check: valid must match queue occupancy and, when
  // valid, the data must match the oldest expected word.
  task automatic checkChannel(input string tag, input logic v, input logic [63:0] o,
                              input int depth, input logic [63:0] front);
    checkOutput({tag, "_valid"}, {63'd0, v}, {63'd0, depth != 0});
    if (v && depth != 0) checkOutput({tag, "_data"}, o, front);
  endtask

  // Scoreboard monitor, decoupled from stimulus. Runs every falling edge
  // outside reset; a word leaves its queue when valid and ready coincide.
  always @(negedge clock) begin
    if (monitorOn && !reset) begin
      checkChannel("ch0", bus.o_riscv_demux3_valid0, bus.o_riscv_demux3_out0,
                   expQ0.size(), (expQ0.size() > 0) ? expQ0[0] : 64'd0);
      checkChannel("ch1", bus.o_riscv_demux3_valid1, bus.o_riscv_demux3_out1,
                   expQ1.size(), (expQ1.size() > 0) ? expQ1[0] : 64'd0);
      checkChannel("ch2", bus.o_riscv_demux3_valid2, bus.o_riscv_demux3_out2,
                   expQ2.size(), (expQ2.size() > 0) ? expQ2[0] : 64'd0);
      checkOutput("drop_cnt", 64'(bus.o_riscv_demux3_drop_cnt), 64'(dropExp));
      checkOutput("busy", {63'd0, bus.o_riscv_demux3_busy},
                  {63'd0, (expQ0.size() + expQ1.size() + expQ2.size()) != 0});
      if (bus.o_riscv_demux3_valid0 && bus.i_riscv_demux3_ready0 && expQ0.size() > 0)
        void'(expQ0.pop_front());
      if (bus.o_riscv_demux3_valid1 && bus.i_riscv_demux3_ready1 && expQ1.size() > 0)
        void'(expQ1.pop_front());
      if (bus.o_riscv_demux3_valid2 && bus.i_riscv_demux3_ready2 && expQ2.size() > 0)
        void'(expQ2.pop_front());
    end
  end

  // Directed checks that every channel is empty with zeroed data and counter.
  task automatic checkCleared(input string tag);
    checkOutput({tag, "_valid0"}, {63'd0, bus.o_riscv_demux3_valid0}, 64'd0);
    checkOutput({tag, "_valid1"}, {63'd0, bus.o_riscv_demux3_valid1}, 64'd0);
    checkOutput({tag, "_valid2"}, {63'd0, bus.o_riscv_demux3_valid2}, 64'd0);
    checkOutput({tag, "_out0"}, bus.o_riscv_demux3_out0, 64'd0);
    checkOutput({tag, "_out1"}, bus.o_riscv_demux3_out1, 64'd0);
    checkOutput({tag, "_out2"}, bus.o_riscv_demux3_out2, 64'd0);
    checkOutput({tag, "_drop"}, 64'(bus.o_riscv_demux3_drop_cnt), 64'd0);
    checkOutput({tag, "_busy"}, {63'd0, bus.o_riscv_demux3_busy}, 64'd0);
  endtask

  initial begin
    int waited;
    bus.i_riscv_demux3_valid  = 1'b0;
    bus.i_riscv_demux3_sel    = 2'b00;
    bus.i_riscv_demux3_in     = '0;
    bus.i_riscv_demux3_ready0 = 1'b0;
    bus.i_riscv_demux3_ready1 = 1'b0;
    bus.i_riscv_demux3_ready2 = 1'b0;

    // Reset, then idle for five cycles.
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    monitorOn = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    checkCleared("idle");
    for (int s = 0; s < 4; s++) begin
      bus.i_riscv_demux3_sel = 2'(s);
      #1 checkOutput($sformatf("idle_ready_sel%0d", s),
                     {63'd0, bus.o_riscv_demux3_ready}, 64'd1);
    end

    // Single route to ch1 with the consumer stalled.
    @(posedge clock);
    #1 applyStimulus(2'b01, 64'hDEAD_BEEF_0000_0001, waited);
    @(negedge clock);
    checkOutput("route_valid1", {63'd0, bus.o_riscv_demux3_valid1}, 64'd1);
    checkOutput("route_out1", bus.o_riscv_demux3_out1, 64'hDEAD_BEEF_0000_0001);
    checkOutput("route_valid0", {63'd0, bus.o_riscv_demux3_valid0}, 64'd0);
    checkOutput("route_valid2", {63'd0, bus.o_riscv_demux3_valid2}, 64'd0);
    bus.i_riscv_demux3_sel = 2'b01;
    #1 checkOutput("full_ready_sel1", {63'd0, bus.o_riscv_demux3_ready}, 64'd0);
    @(posedge clock);
    #1 bus.i_riscv_demux3_ready1 = 1'b1;
    #1 checkOutput("drain_ready_sel1", {63'd0, bus.o_riscv_demux3_ready}, 64'd1);
    @(posedge clock);
    #1 bus.i_riscv_demux3_ready1 = 1'b0;

    // Back-to-back pass-through on ch2 with the consumer always ready.
    bus.i_riscv_demux3_ready2 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(2'b10, 64'(i), waited);
      checkOutput($sformatf("b2b_stall_word%0d", i), 64'(waited), 64'd0);
    end
    @(posedge clock);
    #1 bus.i_riscv_demux3_ready2 = 1'b0;

    // Backpressure on ch0 must not block a word headed for ch2.
    applyStimulus(2'b00, 64'hA0A0_A0A0_A0A0_A0A0, waited);
    applyStimulus(2'b10, 64'd5, waited);
    checkOutput("iso_stall", 64'(waited), 64'd0);
    @(negedge clock);
    checkOutput("iso_valid2", {63'd0, bus.o_riscv_demux3_valid2}, 64'd1);
    checkOutput("iso_out2", bus.o_riscv_demux3_out2, 64'd5);
    checkOutput("iso_valid0", {63'd0, bus.o_riscv_demux3_valid0}, 64'd1);
    checkOutput("iso_out0", bus.o_riscv_demux3_out0, 64'hA0A0_A0A0_A0A0_A0A0);
    @(posedge clock);
    #1 begin
      bus.i_riscv_demux3_ready0 = 1'b1;
      bus.i_riscv_demux3_ready2 = 1'b1;
    end
    @(posedge clock);
    #1 begin
      bus.i_riscv_demux3_ready0 = 1'b0;
      bus.i_riscv_demux3_ready2 = 1'b0;
    end

    // Discard saturation: 300 reserved-code words.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(2'b11, 64'(i), waited);
      if (i == 254) begin
        @(negedge clock);
        checkOutput("drop_at_255th", 64'(bus.o_riscv_demux3_drop_cnt), 64'd255);
      end
    end
    @(negedge clock);
    checkOutput("drop_saturated", 64'(bus.o_riscv_demux3_drop_cnt), 64'd255);
    checkOutput("drop_busy", {63'd0, bus.o_riscv_demux3_busy}, 64'd0);

    // Reset mid-operation with a ch2 accept on the same edge.
    @(posedge clock);
    #1 applyStimulus(2'b00, 64'h1111_1111_1111_1111, waited);
    applyStimulus(2'b01, 64'h2222_2222_2222_2222, waited);
    bus.i_riscv_demux3_valid = 1'b1;
    bus.i_riscv_demux3_sel   = 2'b10;
    bus.i_riscv_demux3_in    = 64'h3333_3333_3333_3333;
    reset = 1'b1;
    @(posedge clock);
    expQ0.delete();
    expQ1.delete();
    expQ2.delete();
    dropExp = '0;
    #1 begin
      reset = 1'b0;
      bus.i_riscv_demux3_valid = 1'b0;
    end
    @(negedge clock);
    checkCleared("midreset");

    // Let the monitor run a few more cycles, then confirm nothing is owed.
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("queues_empty", 64'(expQ0.size() + expQ1.size() + expQ2.size()), 64'd0);

    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule
